wd279x_command_sequencer: RTL and testbench
===========================================

Name: wd279x_command_sequencer

Overview:
- Front-end controller for the WD279x core. Owns the command register and dispatches commands to the Type I, II and III executors as single-cycle starts.
- Implements Type IV Force Interrupt: the abort pulse plus the armed interrupt conditions.
- Muxes executor status and aggregates INTRQ. Generates the shared 1 ms enable, msclk.
- Sits between the CPU register decode and the wd279x_command_I/II/III blocks.

Parameters:
- CLK_HZ, 21477270: system clock frequency, used to derive msclk.
- RESTORE_ON_RESET, 1: when 1, issue Restore (8'h03) to Type I after reset release.

Ports:
- clk  in  1  system clock
- MRn  in  1  master reset, asynchronous, active-low
- cmd_wr  in  1  one-cycle CPU write strobe to the command register
- cmd_data  in  8  CPU write data
- status_rd  in  1  one-cycle CPU read strobe of the status register
- INDEXn  in  1  index pulse from drive, active-low
- READYn  in  1  drive not-ready
- busy_I, busy_II, busy_III  in  1 each  executor busy
- status_I, status_II, status_III  in  8 each  executor status bytes
- intrq_I, intrq_II, intrq_III  in  1 each  executor INTRQ
- command  out  8  latched command register, shared by all executors
- start_I, start_II, start_III  out  1 each  one-cycle command_start strobes
- interrupt  out  1  one-cycle abort pulse to all executors
- msclk  out  1  one-cycle pulse every 1 ms
- status  out  8  selected status byte
- INTRQ  out  1  aggregated interrupt request
- INTRQ_ACK  out  1  equals status_rd; drives executor INTRQ_ACK

Behaviour:
- Reset (MRn=0, asynchronous) forces every output to 0:
  - command=8'h00, start_*=0, interrupt=0, msclk=0, status=8'h00, INTRQ=0.
  - Force flags cleared, sel=TYPE_I, state=ST_RESET.
- Reset release with RESTORE_ON_RESET=1:
  - First clk edge after release: command<=8'h03 and start_I=1 for one cycle, then ST_RUN.
  - With RESTORE_ON_RESET=0: go straight to ST_IDLE.
- msclk: counter 0..CLK_HZ/1000-1. Pulse when the counter wraps. Counter is free-running and is not restarted by commands.
- busy_any = busy_I | busy_II | busy_III.
- Decode of cmd_data:
  - 0xxx_xxxx -> TYPE_I
  - 10xx_xxxx -> TYPE_II
  - 1101_xxxx -> TYPE_IV
  - 1100, 1110, 1111 -> TYPE_III
- States: ST_RESET, ST_IDLE, ST_DISPATCH, ST_RUN.
- ST_IDLE, on cmd_wr with non-IV data:
  - command<=cmd_data, sel<=type, clear all force flags, go to ST_DISPATCH.
- ST_DISPATCH: assert the matching start_x for exactly one cycle, then ST_RUN.
  - Total latency from cmd_wr to start_x is 2 cycles.
- ST_RUN: return to ST_IDLE in the first cycle busy_any=0 that is at least 2 cycles after start.
  - This masks executor startup latency.
- Non-IV cmd_wr while in ST_DISPATCH or ST_RUN: ignored. command is unchanged and there is no start.
- Type IV write, accepted in any state except ST_RESET:
  - command<=cmd_data.
  - interrupt=1 for one cycle only if busy_any or the state is ST_RUN/ST_DISPATCH.
  - Then ST_IDLE. sel is unchanged if an executor was busy; otherwise sel<=TYPE_I.
  - Arm flags from cmd_data[3:0]:
    - I0: not-ready to ready (READYn falling edge).
    - I1: ready to not-ready (READYn rising edge).
    - I2: each INDEXn falling edge.
    - I3: immediate.
  - force_irq is set when an armed event occurs, or on the next cycle for I3.
  - I0–I2 remain armed, and each occurrence re-sets force_irq, until the next command write.
  - force_irq clearing: for I0–I2, status_rd clears force_irq. For I3, force_irq holds until the next cmd_wr (any type) and status_rd does not clear it.
  - 8'hD0 arms nothing and raises no INTRQ.
- Edge detection on INDEXn and READYn uses registered previous values. Inputs are synchronous to clk.
- INTRQ = force_irq | intrq_sel, where intrq_sel is the executor INTRQ selected by sel. Registered output, 1-cycle latency.
- status mux: sel=TYPE_I/II/III selects status_I/II/III. Registered output, 1-cycle latency.
- Simultaneous events:
  - cmd_wr (non-IV) in the same cycle an executor drops busy in ST_RUN: ignored. The CPU must poll BUSY.
  - Type IV and an armed event in the same cycle: the new arm set wins and the old event is discarded.
  - status_rd in the same cycle an I0–I2 event sets force_irq: set wins.

Decomposition:
- wd279x_pkg:
  - cmd_type_t enum {TYPE_I, TYPE_II, TYPE_III, TYPE_IV}
  - seq_state_t enum
  - CMD_RESTORE=8'h03 and CMD_FORCE_NONE=8'hD0
  - Decode function cmd_type(cmd).
- Sub-module wd279x_ms_tick (parameter CLK_HZ; ports clk, MRn, msclk), reused by other FDC blocks.

Test Plan:
- Reset pulse with RESTORE_ON_RESET=1 -> start_I high exactly 1 cycle after MRn rises, command=8'h03; all outputs 0 during reset.
- Idle; write 8'h88 (Read Sector) -> start_II pulses 2 cycles later; status follows status_II; a write of 8'h1C while busy_II=1 is ignored and command stays 8'h88.
- busy_II=1; write 8'hD0 -> interrupt pulses 1 cycle, no start strobe, INTRQ stays 0, state ST_IDLE.
- Write 8'hD8 (I3) -> INTRQ=1 within 2 cycles; status_rd does not clear it; a following write of 8'h00 clears it.
- Write 8'hD4 (I2); drive 3 INDEXn pulses with status_rd between them -> INTRQ asserts 3 times and is cleared by each status_rd.
- CLK_HZ=10000 -> msclk pulses exactly every 10 cycles, uninterrupted across command writes.

Source files
------------

// File: rtl/wd279x_pkg.sv
// -----------------------------------------------------------------------------
// wd279x_pkg
// Shared types and constants for the WD279x front-end command sequencer.
//   cmd_type_t  : command class decoded from the command byte
//   seq_state_t : sequencer FSM states
//   cmd_type()  : decode of a command byte into its class
// -----------------------------------------------------------------------------
package wd279x_pkg;

  typedef enum logic [1:0] {
    TYPE_I   = 2'd0,
    TYPE_II  = 2'd1,
    TYPE_III = 2'd2,
    TYPE_IV  = 2'd3
  } cmd_type_t;

  typedef enum logic [1:0] {
    ST_RESET    = 2'd0,
    ST_IDLE     = 2'd1,
    ST_DISPATCH = 2'd2,
    ST_RUN      = 2'd3
  } seq_state_t;

  localparam logic [7:0] CMD_RESTORE    = 8'h03;
  localparam logic [7:0] CMD_FORCE_NONE = 8'hD0;

  // Bit positions of the Force Interrupt condition field (cmd[3:0]).
  localparam int FI_READY_FALL = 0;  // not-ready -> ready
  localparam int FI_READY_RISE = 1;  // ready -> not-ready
  localparam int FI_INDEX      = 2;  // every index pulse
  localparam int FI_IMMEDIATE  = 3;  // unconditional

  // 0xxx_xxxx Type I, 10xx_xxxx Type II, 1101_xxxx Type IV,
  // remaining 11xx_xxxx codes are Type III.
  function automatic cmd_type_t cmd_type(input logic [7:0] cmd);
    cmd_type_t t;
    if (!cmd[7]) begin
      t = TYPE_I;
    end else if (!cmd[6]) begin
      t = TYPE_II;
    end else if (cmd[5:4] == 2'b01) begin
      t = TYPE_IV;
    end else begin
      t = TYPE_III;
    end
    return t;
  endfunction

endpackage

// File: rtl/wd279x_ms_tick.sv
// -----------------------------------------------------------------------------
// wd279x_ms_tick
// Free-running 1 ms enable generator. The counter runs 0..CLK_HZ/1000-1 and
// msclk pulses for one clock each time it wraps. Nothing but reset restarts it.
//   clk   : system clock
//   MRn   : asynchronous active-low master reset
//   msclk : one-cycle pulse every CLK_HZ/1000 clocks
// -----------------------------------------------------------------------------
module wd279x_ms_tick #(
  parameter int CLK_HZ = 21477270
) (
  input  logic clk,
  input  logic MRn,
  output logic msclk
);

  localparam int DIV_RAW = CLK_HZ / 1000;
  // A divider below 2 would leave the counter with no width; clamp it.
  localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
  localparam int CW      = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          msclk_q, msclk_d;

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    msclk_d = 1'b0;
    if (cnt_q == LAST) begin
      cnt_d   = '0;
      msclk_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge MRn) begin
    if (!MRn) begin
      cnt_q   <= '0;
      msclk_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      msclk_q <= msclk_d;
    end
  end

  assign msclk = msclk_q;

endmodule

// File: rtl/wd279x_command_sequencer.sv
// -----------------------------------------------------------------------------
// wd279x_command_sequencer
// Front end of the WD279x core: owns the command register, dispatches Type
// I/II/III commands to their executors as single-cycle starts, implements the
// Type IV Force Interrupt (abort pulse + armed interrupt conditions), muxes
// executor status and INTRQ, and generates the shared 1 ms enable.
//
// Ports
//   clk, MRn                 : clock, asynchronous active-low master reset
//   cmd_wr, cmd_data[7:0]    : CPU command register write
//   status_rd                : CPU status register read strobe
//   INDEXn, READYn           : drive index pulse / drive not-ready
//   busy_*, status_*, intrq_*: executor feedback (Type I, II, III)
//   command[7:0]             : latched command register
//   start_I/II/III           : one-cycle command start strobes
//   interrupt                : one-cycle abort pulse to all executors
//   msclk                    : one-cycle pulse every 1 ms
//   status[7:0], INTRQ       : registered selected status / aggregated INTRQ
//   INTRQ_ACK                : status_rd passed through to the executors
//   state_dbg[1:0]           : current sequencer state (seq_state_t encoding)
//
// Handshake: every strobe here (cmd_wr, status_rd, start_*, interrupt, msclk)
// is a single-cycle pulse with no ready/backpressure; the receiver must act on
// it in the cycle it is high. A non-IV write that arrives while a command is
// being dispatched or run is dropped; the CPU is expected to poll BUSY.
// -----------------------------------------------------------------------------
module wd279x_command_sequencer
  import wd279x_pkg::*;
#(
  parameter int CLK_HZ           = 21477270,
  parameter bit RESTORE_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       MRn,
  input  logic       cmd_wr,
  input  logic [7:0] cmd_data,
  input  logic       status_rd,
  input  logic       INDEXn,
  input  logic       READYn,
  input  logic       busy_I,
  input  logic       busy_II,
  input  logic       busy_III,
  input  logic [7:0] status_I,
  input  logic [7:0] status_II,
  input  logic [7:0] status_III,
  input  logic       intrq_I,
  input  logic       intrq_II,
  input  logic       intrq_III,
  output logic [7:0] command,
  output logic       start_I,
  output logic       start_II,
  output logic       start_III,
  output logic       interrupt,
  output logic       msclk,
  output logic [7:0] status,
  output logic       INTRQ,
  output logic       INTRQ_ACK,
  output logic [1:0] state_dbg
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  seq_state_t state_q, state_d;
  cmd_type_t  sel_q, sel_d;
  logic [7:0] command_q, command_d;
  logic [2:0] start_q, start_d;        // {III, II, I}
  logic       interrupt_q, interrupt_d;
  logic [1:0] run_cnt_q, run_cnt_d;    // cycles since start, saturates at 2
  logic [2:0] arm_q, arm_d;            // armed I2..I0 conditions
  logic       force_evt_q, force_evt_d; // latched I0-I2 occurrence
  logic       force_imm_q, force_imm_d; // I3 immediate interrupt
  logic       indexn_q, readyn_q;      // previous-cycle pin values
  logic [7:0] status_q;
  logic       intrq_q;

  // ---------------------------------------------------------------------------
  // Decode and event detection
  // ---------------------------------------------------------------------------
  logic       busy_any;
  cmd_type_t  wr_type;
  logic       wr_force;   // Type IV write taking effect this cycle
  logic       wr_accept;  // Type I/II/III write taking effect this cycle
  logic       index_fall, ready_fall, ready_rise, arm_event;
  logic       force_irq, intrq_sel;
  logic [7:0] status_sel;

  assign busy_any   = busy_I | busy_II | busy_III;
  assign wr_type    = cmd_type(cmd_data);
  assign wr_force   = cmd_wr && (wr_type == TYPE_IV) && (state_q != ST_RESET);
  assign wr_accept  = cmd_wr && (wr_type != TYPE_IV) && (state_q == ST_IDLE);

  assign index_fall = indexn_q & ~INDEXn;
  assign ready_fall = readyn_q & ~READYn;
  assign ready_rise = ~readyn_q & READYn;
  assign arm_event  = (arm_q[FI_READY_FALL] & ready_fall)
                    | (arm_q[FI_READY_RISE] & ready_rise)
                    | (arm_q[FI_INDEX]      & index_fall);

  assign force_irq  = force_evt_q | force_imm_q;

  always_comb begin
    intrq_sel  = 1'b0;
    status_sel = 8'h00;
    case (sel_q)
      TYPE_I:   begin intrq_sel = intrq_I;   status_sel = status_I;   end
      TYPE_II:  begin intrq_sel = intrq_II;  status_sel = status_II;  end
      TYPE_III: begin intrq_sel = intrq_III; status_sel = status_III; end
      default:  begin intrq_sel = 1'b0;      status_sel = 8'h00;      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    command_d   = command_q;
    start_d     = 3'b000;
    interrupt_d = 1'b0;
    run_cnt_d   = (run_cnt_q == 2'd2) ? 2'd2 : run_cnt_q + 2'd1;
    arm_d       = arm_q;
    force_imm_d = force_imm_q;

    // An armed event beats a status read landing in the same cycle.
    force_evt_d = force_evt_q;
    if (arm_event) begin
      force_evt_d = 1'b1;
    end else if (status_rd) begin
      force_evt_d = 1'b0;
    end

    case (state_q)
      ST_RESET: begin
        if (RESTORE_ON_RESET) begin
          command_d = CMD_RESTORE;
          sel_d     = TYPE_I;
          start_d   = 3'b001;
          run_cnt_d = 2'd0;
          state_d   = ST_RUN;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (wr_accept) begin
          command_d   = cmd_data;
          sel_d       = wr_type;
          arm_d       = 3'b000;
          force_evt_d = 1'b0;
          force_imm_d = 1'b0;
          state_d     = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        case (sel_q)
          TYPE_I:   start_d = 3'b001;
          TYPE_II:  start_d = 3'b010;
          TYPE_III: start_d = 3'b100;
          default:  start_d = 3'b000;
        endcase
        run_cnt_d = 2'd0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        // The two-cycle hold-off hides the executor's busy rise latency.
        if ((run_cnt_q == 2'd2) && !busy_any) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Force Interrupt overrides whatever the FSM was doing, including a start
    // that would have issued this cycle. The new arm set replaces the old one
    // and any event seen this cycle is discarded.
    if (wr_force) begin
      command_d   = cmd_data;
      interrupt_d = busy_any || (state_q == ST_RUN) || (state_q == ST_DISPATCH);
      start_d     = 3'b000;
      state_d     = ST_IDLE;
      if (!busy_any) begin
        sel_d = TYPE_I;
      end
      arm_d       = cmd_data[FI_INDEX:FI_READY_FALL];
      force_evt_d = 1'b0;
      force_imm_d = cmd_data[FI_IMMEDIATE];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge MRn) begin
    if (!MRn) begin
      state_q     <= ST_RESET;
      sel_q       <= TYPE_I;
      command_q   <= 8'h00;
      start_q     <= 3'b000;
      interrupt_q <= 1'b0;
      run_cnt_q   <= 2'd0;
      arm_q       <= 3'b000;
      force_evt_q <= 1'b0;
      force_imm_q <= 1'b0;
      indexn_q    <= 1'b1;
      readyn_q    <= 1'b1;
      status_q    <= 8'h00;
      intrq_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      command_q   <= command_d;
      start_q     <= start_d;
      interrupt_q <= interrupt_d;
      run_cnt_q   <= run_cnt_d;
      arm_q       <= arm_d;
      force_evt_q <= force_evt_d;
      force_imm_q <= force_imm_d;
      indexn_q    <= INDEXn;
      readyn_q    <= READYn;
      status_q    <= status_sel;
      intrq_q     <= force_irq | intrq_sel;
    end
  end

  wd279x_ms_tick #(.CLK_HZ(CLK_HZ)) u_ms_tick (
    .clk   (clk),
    .MRn   (MRn),
    .msclk (msclk)
  );

  assign command   = command_q;
  assign start_I   = start_q[0];
  assign start_II  = start_q[1];
  assign start_III = start_q[2];
  assign interrupt = interrupt_q;
  assign status    = status_q;
  assign INTRQ     = intrq_q;
  assign INTRQ_ACK = status_rd;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_wd279x_command_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wd279x_command_sequencer
// Directed bench for the WD279x command sequencer: a decode/dispatch vector
// table applied in a loop, plus hand-written sequences for busy handling,
// Force Interrupt conditions and the 1 ms tick.
// -----------------------------------------------------------------------------
module tb_wd279x_command_sequencer;
  import wd279x_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       MRn;
  logic       cmd_wr;
  logic [7:0] cmd_data;
  logic       status_rd;
  logic       INDEXn, READYn;
  logic       busy_I, busy_II, busy_III;
  logic [7:0] status_I, status_II, status_III;
  logic       intrq_I, intrq_II, intrq_III;
  logic [7:0] command;
  logic       start_I, start_II, start_III;
  logic       interrupt, msclk;
  logic [7:0] status;
  logic       INTRQ, INTRQ_ACK;
  logic [1:0] state_dbg;

  wd279x_command_sequencer #(
    .CLK_HZ           (10000),
    .RESTORE_ON_RESET (1'b1)
  ) dut (
    .clk        (clk),
    .MRn        (MRn),
    .cmd_wr     (cmd_wr),
    .cmd_data   (cmd_data),
    .status_rd  (status_rd),
    .INDEXn     (INDEXn),
    .READYn     (READYn),
    .busy_I     (busy_I),
    .busy_II    (busy_II),
    .busy_III   (busy_III),
    .status_I   (status_I),
    .status_II  (status_II),
    .status_III (status_III),
    .intrq_I    (intrq_I),
    .intrq_II   (intrq_II),
    .intrq_III  (intrq_III),
    .command    (command),
    .start_I    (start_I),
    .start_II   (start_II),
    .start_III  (start_III),
    .interrupt  (interrupt),
    .msclk      (msclk),
    .status     (status),
    .INTRQ      (INTRQ),
    .INTRQ_ACK  (INTRQ_ACK),
    .state_dbg  (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and compare helpers
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  int ms_pulses = 0;
  bit mon_on   = 1'b0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input seq_state_t exp);
    check8(name, {6'd0, state_dbg}, {6'd0, exp});
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (all activity 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_cmd(input logic [7:0] d);
    cmd_wr   = 1'b1;
    cmd_data = d;
    tick();
    cmd_wr   = 1'b0;
    cmd_data = 8'h00;
  endtask

  task automatic read_status();
    status_rd = 1'b1;
    tick();
    status_rd = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (state_dbg !== ST_IDLE && k < 20) begin
      tick();
      k++;
    end
    check_state(name, ST_IDLE);
  endtask

  task automatic wait_intrq(input string name);
    int k = 0;
    while (INTRQ !== 1'b1 && k < 6) begin
      tick();
      k++;
    end
    check1(name, INTRQ, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // msclk monitor: every pulse after the first must be exactly 10 clocks on
  // ---------------------------------------------------------------------------
  initial begin
    int gap = 0;
    bit seen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        gap++;
        if (msclk) begin
          if (seen) begin
            check8("msclk_period", 8'(gap), 8'd10);
            ms_pulses++;
          end
          seen = 1'b1;
          gap  = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Vector table: command written from idle with all executors quiet
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [7:0] cmd;
    logic [2:0] exp_start;  // {III, II, I}
    logic       exp_int;
    logic [7:0] exp_status;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  initial begin
    logic [2:0] starts_seen;

    vecs[0] = '{cmd: 8'h03, exp_start: 3'b001, exp_int: 1'b0, exp_status: 8'h11};
    vecs[1] = '{cmd: 8'h88, exp_start: 3'b010, exp_int: 1'b0, exp_status: 8'h22};
    vecs[2] = '{cmd: 8'hD0, exp_start: 3'b000, exp_int: 1'b0, exp_status: 8'h11};
    vecs[3] = '{cmd: 8'hC4, exp_start: 3'b100, exp_int: 1'b0, exp_status: 8'h33};
    vecs[4] = '{cmd: 8'h7F, exp_start: 3'b001, exp_int: 1'b0, exp_status: 8'h11};
    vecs[5] = '{cmd: 8'hBF, exp_start: 3'b010, exp_int: 1'b0, exp_status: 8'h22};
    vecs[6] = '{cmd: 8'hE4, exp_start: 3'b100, exp_int: 1'b0, exp_status: 8'h33};
    vecs[7] = '{cmd: 8'hF4, exp_start: 3'b100, exp_int: 1'b0, exp_status: 8'h33};
    vecs[8] = '{cmd: 8'hD0, exp_start: 3'b000, exp_int: 1'b0, exp_status: 8'h11};

    MRn = 1'b0; cmd_wr = 1'b0; cmd_data = 8'h00; status_rd = 1'b0;
    INDEXn = 1'b1; READYn = 1'b0;
    busy_I = 1'b0; busy_II = 1'b0; busy_III = 1'b0;
    status_I = 8'h11; status_II = 8'h22; status_III = 8'h33;
    intrq_I = 1'b1; intrq_II = 1'b0; intrq_III = 1'b0;

    // ---- reset: all outputs low -------------------------------------------
    tick(3);
    check8("rst_command", command, 8'h00);
    check8("rst_starts", {5'd0, start_III, start_II, start_I}, 8'h00);
    check1("rst_interrupt", interrupt, 1'b0);
    check1("rst_msclk", msclk, 1'b0);
    check8("rst_status", status, 8'h00);
    check1("rst_intrq", INTRQ, 1'b0);
    check_state("rst_state", ST_RESET);

    // ---- release: Restore issued on the first edge ------------------------
    intrq_I = 1'b0;
    MRn     = 1'b1;
    mon_on  = 1'b1;
    tick();
    check1("restore_start_I", start_I, 1'b1);
    check8("restore_command", command, CMD_RESTORE);
    check_state("restore_state", ST_RUN);
    tick();
    check1("restore_start_I_1cyc", start_I, 1'b0);
    check8("restore_status", status, 8'h11);
    wait_idle("restore_idle");

    // ---- table-driven decode / dispatch ----------------------------------
    for (int i = 0; i < NVEC; i++) begin
      write_cmd(vecs[i].cmd);
      check1($sformatf("vec%0d_interrupt", i), interrupt, vecs[i].exp_int);
      tick();
      check8($sformatf("vec%0d_start", i), {5'd0, start_III, start_II, start_I},
             {5'd0, vecs[i].exp_start});
      check8($sformatf("vec%0d_command", i), command, vecs[i].cmd);
      tick();
      check8($sformatf("vec%0d_start_off", i), {5'd0, start_III, start_II, start_I}, 8'h00);
      check8($sformatf("vec%0d_status", i), status, vecs[i].exp_status);
      wait_idle($sformatf("vec%0d_idle", i));
    end

    // ---- Read Sector with busy executor; write while busy is dropped ------
    write_cmd(8'h88);
    busy_II = 1'b1;
    tick();
    check1("rs_start_II", start_II, 1'b1);
    tick();
    check8("rs_status", status, 8'h22);
    intrq_II = 1'b1;
    tick();
    check1("rs_intrq_passthrough", INTRQ, 1'b1);
    intrq_II = 1'b0;
    tick(2);
    check1("rs_intrq_drop", INTRQ, 1'b0);
    write_cmd(8'h1C);
    starts_seen = 3'b000;
    for (int k = 0; k < 4; k++) begin
      starts_seen |= {start_III, start_II, start_I};
      tick();
    end
    check8("busy_wr_no_start", {5'd0, starts_seen}, 8'h00);
    check8("busy_wr_command", command, 8'h88);
    check_state("busy_wr_state", ST_RUN);

    // ---- D0 while busy: abort pulse only -------------------------------
    write_cmd(CMD_FORCE_NONE);
    check1("d0_interrupt", interrupt, 1'b1);
    check8("d0_command", command, 8'hD0);
    check_state("d0_state", ST_IDLE);
    tick();
    check1("d0_interrupt_1cyc", interrupt, 1'b0);
    check8("d0_no_start", {5'd0, start_III, start_II, start_I}, 8'h00);
    check1("d0_intrq", INTRQ, 1'b0);
    check8("d0_sel_kept", status, 8'h22);
    busy_II = 1'b0;
    tick(2);

    // ---- D8: immediate interrupt, immune to status reads ----------------
    write_cmd(8'hD8);
    check1("i3_no_abort", interrupt, 1'b0);
    tick();
    check1("i3_intrq", INTRQ, 1'b1);
    status_rd = 1'b1;
    #1;
    check1("intrq_ack", INTRQ_ACK, 1'b1);
    tick();
    status_rd = 1'b0;
    tick();
    check1("i3_hold_after_rd", INTRQ, 1'b1);
    write_cmd(8'h00);
    tick();
    check1("i3_clear_by_write", INTRQ, 1'b0);
    wait_idle("i3_idle");

    // ---- D4: every index pulse, each cleared by a status read -----------
    write_cmd(8'hD4);
    tick(2);
    check1("i2_armed_quiet", INTRQ, 1'b0);
    for (int p = 0; p < 3; p++) begin
      INDEXn = 1'b0;
      wait_intrq($sformatf("i2_pulse%0d_intrq", p));
      INDEXn = 1'b1;
      tick();
      read_status();
      tick();
      check1($sformatf("i2_pulse%0d_rd_clear", p), INTRQ, 1'b0);
    end
    // Event and status read in the same cycle: the event wins.
    INDEXn    = 1'b0;
    status_rd = 1'b1;
    tick();
    INDEXn    = 1'b1;
    status_rd = 1'b0;
    tick();
    check1("i2_set_beats_rd", INTRQ, 1'b1);
    read_status();
    tick();
    check1("i2_final_clear", INTRQ, 1'b0);

    // A normal command disarms the index condition.
    write_cmd(8'h00);
    wait_idle("disarm_idle");
    INDEXn = 1'b0;
    tick();
    INDEXn = 1'b1;
    tick(3);
    check1("i2_disarmed", INTRQ, 1'b0);

    // ---- D2: ready -> not-ready only -------------------------------------
    write_cmd(8'hD2);
    tick(2);
    check1("i1_armed_quiet", INTRQ, 1'b0);
    READYn = 1'b1;
    wait_intrq("i1_ready_rise");
    read_status();
    tick();
    check1("i1_rd_clear", INTRQ, 1'b0);
    READYn = 1'b0;
    tick(3);
    check1("i1_ignores_ready_fall", INTRQ, 1'b0);

    // ---- final report ---------------------------------------------------
    tick(12);
    mon_on = 1'b0;
    check1("msclk_pulses_seen", ms_pulses >= 10, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
